// File: rtl/seg_link_pkg.sv
// ---------------------------------------------------------------------------
// seg_link_pkg
// Shared definitions for the 7-segment serial shift-out link (transmitter
// stimulus and receiver/checker).
//   seg_state_t        : receiver frame state (IDLE, SHIFT, OVER)
//   DIR_MSB_FIRST/LSB  : bit-order selectors for the DIR parameter
//   DEFAULT_DATA_BITS  : default frame width
// ---------------------------------------------------------------------------
package seg_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } seg_state_t;

    localparam int DIR_MSB_FIRST     = 1;
    localparam int DIR_LSB_FIRST     = 0;
    localparam int DEFAULT_DATA_BITS = 64;

endpackage

// File: rtl/sig_sync_edge.sv
// ---------------------------------------------------------------------------
// sig_sync_edge
// Brings one asynchronous wire into the clk domain: 2-FF synchronizer, a
// history FF, and registered rise/fall pulses. The level output is the
// history FF, so it is cycle-aligned with the rise/fall pulses.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input
//   level    : synchronized level (aligned with rise/fall)
//   rise     : one-cycle pulse on a 0->1 transition
//   fall     : one-cycle pulse on a 1->0 transition
// ---------------------------------------------------------------------------
module sig_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       hist_reg;
    logic       rise_reg;
    logic       fall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            hist_reg <= sync_reg[1];
            rise_reg <= sync_reg[1] & ~hist_reg;
            fall_reg <= ~sync_reg[1] & hist_reg;
        end
    end

    assign level = hist_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/s2p_seg_receiver.sv
// ---------------------------------------------------------------------------
// s2p_seg_receiver
// Serial-to-parallel receiver for the 7-segment shift-out link. The four
// link wires are oversampled in the clk domain; bits are shifted in on
// s_clk rising edges and the shift register is latched to pdata on an EN
// rising edge.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   s_clk        : serial shift clock (asynchronous)
//   sout         : serial data
//   s_clrn       : active-low shift-register clear
//   EN           : latch strobe, rising-edge active
//   pdata        : last latched frame
//   pdata_valid  : one-cycle pulse when pdata updates
//   frame_err    : sticky; set by a bad-length latch or a timeout,
//                  cleared by the next good latch
//   bit_cnt      : bits shifted in the current frame (saturates DATA_BITS+1)
// ---------------------------------------------------------------------------
module s2p_seg_receiver
    import seg_link_pkg::*;
#(
    parameter int DATA_BITS       = DEFAULT_DATA_BITS,
    parameter int DATA_COUNT_BITS = 6,
    parameter int DIR             = DIR_MSB_FIRST,
    parameter int TIMEOUT         = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_clk,
    input  logic                       sout,
    input  logic                       s_clrn,
    input  logic                       EN,
    output logic [DATA_BITS-1:0]       pdata,
    output logic                       pdata_valid,
    output logic                       frame_err,
    output logic [DATA_COUNT_BITS:0]   bit_cnt
);

    localparam int CNT_W = DATA_COUNT_BITS + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_BITS + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    // Wire order in the synchronizer bank: 0=s_clk 1=sout 2=s_clrn 3=EN
    logic [3:0] raw_in;
    logic [3:0] sync_level;
    logic [3:0] sync_rise;
    logic [3:0] sync_fall;

    assign raw_in = {EN, s_clrn, sout, s_clk};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        sig_sync_edge u_sync (
            .clk   (clk),
            .rst   (rst),
            .din   (raw_in[gi]),
            .level (sync_level[gi]),
            .rise  (sync_rise[gi]),
            .fall  (sync_fall[gi])
        );
    end

    // sout is taken from the same pipeline stage as the s_clk edge pulse.
    logic clk_rise;
    logic sout_s;
    logic clrn_s;
    logic en_rise;

    assign clk_rise = sync_rise[0];
    assign sout_s   = sync_level[1];
    assign clrn_s   = sync_level[2];
    assign en_rise  = sync_rise[3];

    logic unused_sync;
    assign unused_sync = ^{sync_level[3], sync_level[0], sync_rise[2:1], sync_fall};

    seg_state_t           state_reg, state_next;
    logic [DATA_BITS-1:0] sr_reg, sr_next, sr_shift;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [TO_W-1:0]      to_cnt_reg, to_cnt_next;
    logic [DATA_BITS-1:0] pdata_reg, pdata_next;
    logic                 valid_reg, valid_next;
    logic                 err_reg, err_next;

    if (DIR == DIR_MSB_FIRST) begin : g_msb_first
        assign sr_shift = {sr_reg[DATA_BITS-2:0], sout_s};
    end else begin : g_lsb_first
        assign sr_shift = {sout_s, sr_reg[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            sr_reg     <= '0;
            cnt_reg    <= '0;
            to_cnt_reg <= '0;
            pdata_reg  <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sr_reg     <= sr_next;
            cnt_reg    <= cnt_next;
            to_cnt_reg <= to_cnt_next;
            pdata_reg  <= pdata_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
        end
    end

    // Shift is resolved first so a coincident latch sees the new bit and
    // the updated count; clear overrides both.
    always_comb begin
        state_next  = state_reg;
        sr_next     = sr_reg;
        cnt_next    = cnt_reg;
        to_cnt_next = to_cnt_reg;
        pdata_next  = pdata_reg;
        valid_next  = 1'b0;
        err_next    = err_reg;

        if (!clrn_s) begin
            state_next  = IDLE;
            sr_next     = '0;
            cnt_next    = '0;
            to_cnt_next = '0;
        end else begin
            if (clk_rise) begin
                sr_next     = sr_shift;
                cnt_next    = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
                to_cnt_next = '0;
                if (state_reg == IDLE) begin
                    state_next = SHIFT;
                end else if (cnt_next > CNT_FULL) begin
                    state_next = OVER;
                end
            end else if (state_reg != IDLE) begin
                // Stalled frame: abort but keep the register contents.
                if (to_cnt_reg == TO_LAST) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    to_cnt_next = '0;
                    err_next    = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            if (en_rise) begin
                pdata_next  = sr_next;
                valid_next  = 1'b1;
                err_next    = (cnt_next != CNT_FULL);
                state_next  = IDLE;
                cnt_next    = '0;
                to_cnt_next = '0;
            end
        end
    end

    assign pdata       = pdata_reg;
    assign pdata_valid = valid_reg;
    assign frame_err   = err_reg;
    assign bit_cnt     = cnt_reg;

endmodule

// File: tb/tb_s2p_seg_receiver.sv
// ---------------------------------------------------------------------------
// tb_s2p_seg_receiver
// Two receivers share one link: a 64-bit MSB-first instance and an 8-bit
// LSB-first instance, both with a short frame timeout. Expected frames come
// from a bit-history model (last N bits received since the last clear or
// reset, placed by bit order) and from a table of hand-computed frames.
// ---------------------------------------------------------------------------
module tb_s2p_seg_receiver;
    import seg_link_pkg::*;

    logic clk = 1'b0;
    logic rst, s_clk, sout, s_clrn, EN;

    logic [63:0] pdata64;
    logic        valid64, err64;
    logic [6:0]  cnt64;
    logic [7:0]  pdata8;
    logic        valid8, err8;
    logic [3:0]  cnt8;

    always #5 clk = ~clk;

    s2p_seg_receiver #(
        .DATA_BITS(64), .DATA_COUNT_BITS(6), .DIR(DIR_MSB_FIRST), .TIMEOUT(16)
    ) dut64 (
        .clk(clk), .rst(rst), .s_clk(s_clk), .sout(sout), .s_clrn(s_clrn), .EN(EN),
        .pdata(pdata64), .pdata_valid(valid64), .frame_err(err64), .bit_cnt(cnt64)
    );

    s2p_seg_receiver #(
        .DATA_BITS(8), .DATA_COUNT_BITS(3), .DIR(DIR_LSB_FIRST), .TIMEOUT(16)
    ) dut8 (
        .clk(clk), .rst(rst), .s_clk(s_clk), .sout(sout), .s_clrn(s_clrn), .EN(EN),
        .pdata(pdata8), .pdata_valid(valid8), .frame_err(err8), .bit_cnt(cnt8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: every bit received since the last clear/reset, and
    // the number of bits since the last latch/clear/timeout/reset.
    logic hist_q[$];
    int   nb = 0;

    typedef struct {
        int           nbits;
        logic [127:0] data;
        bit           clr_first;
        logic [63:0]  exp_pdata;
        logic         exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] exp_word(input int n, input int dir);
        logic [63:0] w;
        logic        b;
        w = '0;
        for (int i = 0; i < n; i++) begin
            if (i < hist_q.size()) begin
                b = hist_q[hist_q.size() - 1 - i];
                if (dir == DIR_MSB_FIRST) w[i] = b;
                else w[n - 1 - i] = b;
            end
        end
        return w;
    endfunction

    function automatic int sat_cnt(input int n);
        return (nb > n + 1) ? n + 1 : nb;
    endfunction

    // Drives one bit and raises s_clk; returns at the negedge of the rise.
    task automatic send_bit_rise(input logic b);
        @(negedge clk);
        s_clk = 1'b0;
        sout  = b;
        repeat (4) @(negedge clk);
        s_clk = 1'b1;
        hist_q.push_back(b);
        if (hist_q.size() > 64) void'(hist_q.pop_front());
        nb++;
    endtask

    task automatic send_bits(input logic [127:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit_rise(d[i]);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        s_clrn = 1'b0;
        repeat (5) @(negedge clk);
        s_clrn = 1'b1;
        repeat (5) @(negedge clk);
        hist_q.delete();
        nb = 0;
    endtask

    // Raises EN now and checks latency, pulse width and latched contents.
    task automatic do_latch(input string name);
        logic [63:0] e64, t;
        logic [7:0]  e8;
        logic        ee64, ee8;
        logic        quiet;
        e64  = exp_word(64, DIR_MSB_FIRST);
        t    = exp_word(8, DIR_LSB_FIRST);
        e8   = t[7:0];
        ee64 = (nb != 64);
        ee8  = (nb != 8);
        nb   = 0;
        EN   = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (valid64 || valid8) quiet = 1'b0;
        end
        chk({name, "_early_valid"}, 64'(quiet), 64'd1);
        @(negedge clk);
        chk({name, "_valid64"}, 64'(valid64), 64'd1);
        chk({name, "_valid8"},  64'(valid8),  64'd1);
        chk({name, "_pdata64"}, pdata64, e64);
        chk({name, "_pdata8"},  64'(pdata8), 64'(e8));
        chk({name, "_err64"},   64'(err64), 64'(ee64));
        chk({name, "_err8"},    64'(err8),  64'(ee8));
        chk({name, "_cnt64"},   64'(cnt64), 64'd0);
        @(negedge clk);
        chk({name, "_pulse_width"}, 64'(valid64 | valid8), 64'd0);
        EN = 1'b0;
        repeat (4) @(negedge clk);
        $display("latch %s: pdata64=%h err64=%b pdata8=%h err8=%b",
                 name, pdata64, err64, pdata8, err8);
    endtask

    initial begin
        logic         quiet;
        logic [127:0] rnd;
        int           n;

        vecs[0] = '{64, 128'h0123_4567_89AB_CDEF,       1'b0, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[1] = '{63, 128'h7EDC_BA98_7654_3210,       1'b1, 64'h7EDC_BA98_7654_3210, 1'b1};
        vecs[2] = '{66, 128'h2_DEAD_BEEF_CAFE_F00D,     1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1};
        vecs[3] = '{64, 128'h1111_2222_3333_4444,       1'b0, 64'h1111_2222_3333_4444, 1'b0};

        rst = 1'b1; s_clk = 1'b0; sout = 1'b0; s_clrn = 1'b1; EN = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pdata", pdata64, 64'd0);
        chk("reset_valid", 64'(valid64), 64'd0);
        chk("reset_err",   64'(err64), 64'd0);
        chk("reset_cnt",   64'(cnt64), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Table-driven frames on the 64-bit receiver.
        for (int r = 0; r < 4; r++) begin
            if (vecs[r].clr_first) do_clear();
            send_bits(vecs[r].data, vecs[r].nbits);
            chk($sformatf("row%0d_bitcnt", r), 64'(cnt64), 64'(sat_cnt(64)));
            if (vecs[r].nbits > 64) chk($sformatf("row%0d_over", r), 64'(dut64.state_reg), 64'(OVER));
            do_latch($sformatf("row%0d", r));
            chk($sformatf("row%0d_tbl_pdata", r), pdata64, vecs[r].exp_pdata);
            chk($sformatf("row%0d_tbl_err", r), 64'(err64), 64'(vecs[r].exp_err));
        end

        // 64th s_clk edge and EN edge arrive together.
        send_bits(128'hA5A5_5A5A_C3C3_3C3C >> 1, 63);
        send_bit_rise(1'b0);
        do_latch("coincident");
        chk("coincident_pdata", pdata64, 64'hA5A5_5A5A_C3C3_3C3C);
        chk("coincident_err", 64'(err64), 64'd0);

        // 8-bit LSB-first frame 8'hA5 (bit 0 first).
        send_bits(128'hA5, 8);
        do_latch("lsb8");
        chk("lsb8_pdata", 64'(pdata8), 64'hA5);
        chk("lsb8_err", 64'(err8), 64'd0);

        // Clear mid-frame with an EN edge inside the clear window.
        send_bits(128'h5_A5A5, 20);
        chk("clr_pre_cnt", 64'(cnt64), 64'd20);
        @(negedge clk);
        s_clrn = 1'b0;
        hist_q.delete();
        nb = 0;
        @(negedge clk);
        EN = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid64 || valid8) quiet = 1'b0;
            if (i == 2) EN = 1'b0;
            if (i == 3) s_clrn = 1'b1;
        end
        chk("clr_no_valid", 64'(quiet), 64'd1);
        chk("clr_cnt", 64'(cnt64), 64'd0);
        send_bits(128'hFFFF_0000_FFFF_0000, 64);
        do_latch("after_clear");
        chk("after_clear_pdata", pdata64, 64'hFFFF_0000_FFFF_0000);
        chk("after_clear_err", 64'(err64), 64'd0);

        // Stalled frame times out.
        send_bits(128'h2B5, 10);
        quiet = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid64 || valid8) quiet = 1'b0;
        end
        nb = 0;
        chk("timeout_no_valid", 64'(quiet), 64'd1);
        chk("timeout_err64", 64'(err64), 64'd1);
        chk("timeout_err8",  64'(err8), 64'd1);
        chk("timeout_cnt64", 64'(cnt64), 64'd0);
        chk("timeout_cnt8",  64'(cnt8), 64'd0);
        chk("timeout_pdata_held", pdata64, 64'hFFFF_0000_FFFF_0000);

        // Randomized frame lengths and contents.
        for (int f = 0; f < 6; f++) begin
            rnd = {32'h0, $urandom, $urandom, $urandom};
            n   = (f == 0) ? 0 : $urandom_range(1, 70);
            send_bits(rnd, n);
            chk($sformatf("rand%0d_cnt64", f), 64'(cnt64), 64'(sat_cnt(64)));
            chk($sformatf("rand%0d_cnt8", f),  64'(cnt8),  64'(sat_cnt(8)));
            do_latch($sformatf("rand%0d_n%0d", f, n));
        end

        // Reset mid-frame discards the partial frame.
        send_bits(128'hF_0F0F, 20);
        @(negedge clk);
        rst   = 1'b1;
        s_clk = 1'b0;
        @(negedge clk);
        chk("rst_pdata", pdata64, 64'd0);
        chk("rst_valid", 64'(valid64), 64'd0);
        chk("rst_err",   64'(err64), 64'd0);
        chk("rst_cnt",   64'(cnt64), 64'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        hist_q.delete();
        nb = 0;
        repeat (6) @(negedge clk);
        send_bits(128'hCAFE_BABE_1234_5678, 64);
        do_latch("post_rst");
        chk("post_rst_pdata", pdata64, 64'hCAFE_BABE_1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
